// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the intersection controller.
//   phase_t      - controller phases
//   DEF_*        - default parameter values for the controller
//   timer_width  - width of the shared phase timer for a set of durations
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED,
        GREEN,
        YELLOW,
        FLASH
    } phase_t;

    localparam int DEF_NUM_DIR    = 4;
    localparam int DEF_CLR_T      = 2;
    localparam int DEF_GREEN_T    = 15;
    localparam int DEF_YELLOW_T   = 5;
    localparam int DEF_WALK_T     = 8;
    localparam int DEF_FLASH_HALF = 4;

    // Bits needed to count 0..max(durations); never less than 1.
    function automatic int timer_width(input int clr_t, input int green_t, input int yellow_t);
        int longest;
        longest = clr_t;
        if (green_t > longest) longest = green_t;
        if (yellow_t > longest) longest = yellow_t;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/tl_blink_gen.sv
// tl_blink_gen: square-wave generator for the flashing-yellow mode.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - run the generator; while low it is parked at blink=1, count 0
//   blink      - toggles every FLASH_HALF enabled cycles, starting high
module tl_blink_gen
    import traffic_pkg::*;
#(
    parameter int FLASH_HALF = DEF_FLASH_HALF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic blink
);

    localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(FLASH_HALF - 1);

    logic [CW-1:0] cnt;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            blink <= ~blink;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: round-robin traffic-light controller with
// latched pedestrian requests and a flashing-yellow night mode.
//   clk, rst_n  - clock, asynchronous active-low reset
//   flash_req   - level request for night flashing mode
//   ped_req     - per-approach pedestrian button (one-cycle pulse is enough)
//   red/yellow/green - registered lamp drives, one bit per approach
//   walk        - registered pedestrian walk signal per approach
//   cur_dir     - approach being served, aligned with the lamp outputs
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = DEF_NUM_DIR,
    parameter int CLR_T      = DEF_CLR_T,
    parameter int GREEN_T    = DEF_GREEN_T,
    parameter int YELLOW_T   = DEF_YELLOW_T,
    parameter int WALK_T     = DEF_WALK_T,
    parameter int FLASH_HALF = DEF_FLASH_HALF,
    localparam int DW        = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flash_req,
    input  logic [NUM_DIR-1:0] ped_req,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [NUM_DIR-1:0] walk,
    output logic [DW-1:0]      cur_dir
);

    localparam int TW = timer_width(CLR_T, GREEN_T, YELLOW_T);

    localparam logic [TW-1:0] CLR_END    = TW'(CLR_T - 1);
    localparam logic [TW-1:0] GREEN_END  = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] YELLOW_END = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] WALK_LIM   = TW'(WALK_T);
    localparam logic [DW-1:0] LAST_DIR   = DW'(NUM_DIR - 1);

    // Parameter range checks, evaluated at elaboration.
    if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_num_dir
        $error("NUM_DIR must be in 2..8");
    end
    if (CLR_T < 1 || GREEN_T < 1 || YELLOW_T < 1) begin : g_bad_durations
        $error("CLR_T, GREEN_T and YELLOW_T must be at least 1");
    end
    if (WALK_T < 1 || WALK_T > GREEN_T) begin : g_bad_walk
        $error("WALK_T must be in 1..GREEN_T");
    end
    if (FLASH_HALF < 1) begin : g_bad_flash
        $error("FLASH_HALF must be at least 1");
    end

    phase_t             state;
    logic [TW-1:0]      timer;
    logic [DW-1:0]      dir;
    logic [NUM_DIR-1:0] ped_pend;
    logic               walk_grant;   // walk decision taken on entry to this green
    logic               blink;

    logic [NUM_DIR-1:0] dir_mask;
    logic               entry;        // first cycle spent in GREEN
    logic               hit;          // served approach has a request at entry
    logic               walk_now;

    assign dir_mask = NUM_DIR'(1) << dir;
    assign entry    = (state == GREEN) && (timer == '0);
    // A press in the entry cycle itself counts, so it is ORed in directly.
    assign hit      = entry && (|((ped_pend | ped_req) & dir_mask));
    assign walk_now = (entry ? hit : walk_grant) && (timer < WALK_LIM);

    tl_blink_gen #(
        .FLASH_HALF (FLASH_HALF)
    ) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == FLASH),
        .blink (blink)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ALL_RED;
            timer      <= '0;
            dir        <= '0;
            ped_pend   <= '0;
            walk_grant <= 1'b0;
            red        <= '1;
            yellow     <= '0;
            green      <= '0;
            walk       <= '0;
            cur_dir    <= '0;
        end else begin
            // Lamps decode the current (pre-edge) phase, so they trail the
            // phase register by one cycle and never depend on inputs.
            // NOTE: every lamp gets a safe default first and the case below
            // only overrides it; the last non-blocking write wins.
            red     <= '1;
            yellow  <= '0;
            green   <= '0;
            walk    <= '0;
            cur_dir <= dir;
            case (state)
                GREEN: begin
                    red   <= ~dir_mask;
                    green <= dir_mask;
                    if (walk_now) walk <= dir_mask;
                end
                YELLOW: begin
                    red    <= ~dir_mask;
                    yellow <= dir_mask;
                end
                FLASH: begin
                    red    <= '0;
                    yellow <= {NUM_DIR{blink}};
                end
                default: ;
            endcase

            // Requests latch in every phase; only a green entry consumes one.
            ped_pend <= (ped_pend | ped_req) & ~(hit ? dir_mask : '0);
            if (entry) walk_grant <= hit;

            timer <= timer + TW'(1);
            case (state)
                ALL_RED: begin
                    if (timer == CLR_END) begin
                        timer <= '0;
                        state <= flash_req ? FLASH : GREEN;
                    end
                end
                GREEN: begin
                    // A flash request cuts green short but still goes through a full yellow.
                    if (flash_req || timer == GREEN_END) begin
                        timer <= '0;
                        state <= YELLOW;
                    end
                end
                YELLOW: begin
                    if (timer == YELLOW_END) begin
                        timer <= '0;
                        if (flash_req) begin
                            state <= FLASH;
                        end else begin
                            state <= ALL_RED;
                            dir   <= (dir == LAST_DIR) ? '0 : dir + DW'(1);
                        end
                    end
                end
                FLASH: begin
                    if (!flash_req) begin
                        timer <= '0;
                        state <= ALL_RED;
                        dir   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
